// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch prediction tracking / redirect logic.
package branch_ctrl_pkg;

    localparam int INSTR_BYTES    = 4;
    // Queue entries carry full 32-bit addresses; narrower PCs are zero-extended.
    localparam int ENTRY_PC_WIDTH = 32;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic [ENTRY_PC_WIDTH-1:0] pc;
        logic                      predict_taken;
        logic [ENTRY_PC_WIDTH-1:0] pred_target;
    } pred_entry_t;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of outstanding predictions; head entry is visible combinationally.
module pred_queue #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW:0]      count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Clear wins over a same-cycle push/pop so wrong-path writes vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Tracks fetch-stage predictions to execute resolution; flushes and redirects on mispredict.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int QDEPTH     = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_push,
    input  logic [DATA_WIDTH-1:0] f_pc,
    input  logic                  f_predict_taken,
    input  logic [DATA_WIDTH-1:0] f_pred_target,
    input  logic                  e_resolve,
    input  logic                  e_actual_taken,
    input  logic [DATA_WIDTH-1:0] e_actual_target,
    output logic                  stall_f,
    output logic                  flush_fd,
    output logic                  flush_de,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count,
    output logic                  underflow_err
);
    localparam int EW = $bits(pred_entry_t);

    state_t                  state_reg;
    pred_entry_t             wr_entry;
    pred_entry_t             head;
    logic [EW-1:0]           head_bits;
    logic [$clog2(QDEPTH):0] q_count;
    logic                    q_full;
    logic                    q_empty;
    logic                    push;
    logic                    pop;
    logic                    mispredict;
    logic                    underflow;
    logic [DATA_WIDTH-1:0]   head_pc;
    logic [DATA_WIDTH-1:0]   head_target;
    logic [DATA_WIDTH-1:0]   correct_pc;

    assign pop       = e_resolve && !q_empty && (state_reg == RUN);
    assign underflow = e_resolve && q_empty && (state_reg == RUN);
    assign stall_f   = q_full && !pop;
    assign push      = f_push && !stall_f && (state_reg == RUN);

    assign wr_entry.pc            = ENTRY_PC_WIDTH'(f_pc);
    assign wr_entry.predict_taken = f_predict_taken;
    assign wr_entry.pred_target   = ENTRY_PC_WIDTH'(f_pred_target);

    pred_queue #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (state_reg == RECOVER),
        .wdata (wr_entry),
        .rdata (head_bits),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign head        = head_bits;
    assign head_pc     = DATA_WIDTH'(head.pc);
    assign head_target = DATA_WIDTH'(head.pred_target);

    // Direction mismatch, or both taken but to different addresses (JALR).
    assign mispredict = pop && ((e_actual_taken != head.predict_taken) ||
                                (e_actual_taken && head.predict_taken &&
                                 (e_actual_target != head_target)));
    assign correct_pc = e_actual_taken ? e_actual_target
                                       : head_pc + DATA_WIDTH'(INSTR_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN;
            flush_fd         <= 1'b0;
            flush_de         <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            underflow_err    <= 1'b0;
        end else begin
            flush_fd       <= 1'b0;
            flush_de       <= 1'b0;
            redirect_valid <= 1'b0;
            unique case (state_reg)
                RUN: begin
                    if (mispredict) begin
                        state_reg      <= RECOVER;
                        flush_fd       <= 1'b1;
                        flush_de       <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= correct_pc;
                    end
                end
                RECOVER: state_reg <= RUN;
            endcase
            if (pop && (branch_count != '1))
                branch_count <= branch_count + 1'b1;
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 1'b1;
            if (underflow)
                underflow_err <= 1'b1;
        end
    end

    // Only the low count bits are observed through q_full/q_empty.
    logic unused_ok;
    assign unused_ok = ^q_count;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed table-driven bench for branch_redirect_ctrl plus reset and saturation sequences.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_push, f_predict_taken, e_resolve, e_actual_taken;
    logic [31:0] f_pc, f_pred_target, e_actual_target;
    logic        stall_f, flush_fd, flush_de, redirect_valid, underflow_err;
    logic [31:0] redirect_pc, branch_count, mispredict_count;

    logic        s_push, s_pt, s_res, s_at;
    logic [31:0] s_pc, s_ptgt, s_atgt;
    logic        s_stall, s_ffd, s_fde, s_rv, s_uf;
    logic [31:0] s_rpc;
    logic [1:0]  s_bc, s_mc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.DATA_WIDTH(32), .QDEPTH(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_push(f_push), .f_pc(f_pc), .f_predict_taken(f_predict_taken),
        .f_pred_target(f_pred_target),
        .e_resolve(e_resolve), .e_actual_taken(e_actual_taken),
        .e_actual_target(e_actual_target),
        .stall_f(stall_f), .flush_fd(flush_fd), .flush_de(flush_de),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .underflow_err(underflow_err)
    );

    branch_redirect_ctrl #(.DATA_WIDTH(32), .QDEPTH(2), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .f_push(s_push), .f_pc(s_pc), .f_predict_taken(s_pt),
        .f_pred_target(s_ptgt),
        .e_resolve(s_res), .e_actual_taken(s_at), .e_actual_target(s_atgt),
        .stall_f(s_stall), .flush_fd(s_ffd), .flush_de(s_fde),
        .redirect_valid(s_rv), .redirect_pc(s_rpc),
        .branch_count(s_bc), .mispredict_count(s_mc), .underflow_err(s_uf)
    );

    typedef struct {
        logic        push;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        res;
        logic        at;
        logic [31:0] atgt;
        logic        exp_stall;
        logic        exp_flush;
        logic [31:0] exp_rpc;
        int          exp_bc;
        int          exp_mc;
        logic        exp_uf;
        int          exp_cnt;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    function automatic vec_t mk(logic push, logic [31:0] pc, logic pt, logic [31:0] ptgt,
                                logic res, logic at, logic [31:0] atgt, logic st,
                                logic fl, logic [31:0] rpc, int bc, int mc, logic uf, int cnt);
        vec_t v;
        v.push = push; v.pc = pc; v.pt = pt; v.ptgt = ptgt;
        v.res = res; v.at = at; v.atgt = atgt;
        v.exp_stall = st; v.exp_flush = fl; v.exp_rpc = rpc;
        v.exp_bc = bc; v.exp_mc = mc; v.exp_uf = uf; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_main();
        f_push = 0; f_pc = 0; f_predict_taken = 0; f_pred_target = 0;
        e_resolve = 0; e_actual_taken = 0; e_actual_target = 0;
    endtask

    initial begin
        // push pc pt ptgt | res at atgt | stall flush rpc bc mc uf cnt
        vecs[0]  = mk(1, 32'h100, 1, 32'h0F0, 0, 0, 0,       0, 0, 32'h000, 0, 0, 0, 1);
        vecs[1]  = mk(0, 0, 0, 0,             1, 1, 32'h0F0, 0, 0, 32'h000, 1, 0, 0, 0);
        vecs[2]  = mk(1, 32'h200, 0, 0,       0, 0, 0,       0, 0, 32'h000, 1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0,             1, 1, 32'h240, 0, 1, 32'h240, 2, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,             0, 0, 0,       0, 0, 32'h240, 2, 1, 0, 0);
        vecs[5]  = mk(1, 32'h300, 1, 32'h2F0, 0, 0, 0,       0, 0, 32'h240, 2, 1, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0,             1, 0, 0,       0, 1, 32'h304, 3, 2, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0,             0, 0, 0,       0, 0, 32'h304, 3, 2, 0, 0);
        vecs[8]  = mk(1, 32'h400, 0, 0,       0, 0, 0,       0, 0, 32'h304, 3, 2, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0,             1, 1, 32'h800, 0, 1, 32'h800, 4, 3, 0, 0);
        vecs[10] = mk(0, 0, 0, 0,             0, 0, 0,       0, 0, 32'h800, 4, 3, 0, 0);
        vecs[11] = mk(1, 32'h500, 1, 32'h520, 0, 0, 0,       0, 0, 32'h800, 4, 3, 0, 1);
        vecs[12] = mk(0, 0, 0, 0,             1, 1, 32'h530, 0, 1, 32'h530, 5, 4, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,             0, 0, 0,       0, 0, 32'h530, 5, 4, 0, 0);
        // fill to capacity, drop a push, then push+pop across pointer wrap
        vecs[14] = mk(1, 32'h600, 1, 32'h680, 0, 0, 0,       0, 0, 32'h530, 5, 4, 0, 1);
        vecs[15] = mk(1, 32'h604, 0, 0,       0, 0, 0,       0, 0, 32'h530, 5, 4, 0, 2);
        vecs[16] = mk(1, 32'h608, 1, 32'h688, 0, 0, 0,       0, 0, 32'h530, 5, 4, 0, 3);
        vecs[17] = mk(1, 32'h60C, 0, 0,       0, 0, 0,       0, 0, 32'h530, 5, 4, 0, 4);
        vecs[18] = mk(1, 32'h700, 1, 32'h7F0, 0, 0, 0,       1, 0, 32'h530, 5, 4, 0, 4);
        vecs[19] = mk(1, 32'h710, 1, 32'h780, 1, 1, 32'h680, 0, 0, 32'h530, 6, 4, 0, 4);
        vecs[20] = mk(0, 0, 0, 0,             1, 0, 0,       0, 0, 32'h530, 7, 4, 0, 3);
        vecs[21] = mk(0, 0, 0, 0,             1, 1, 32'h688, 0, 0, 32'h530, 8, 4, 0, 2);
        vecs[22] = mk(0, 0, 0, 0,             1, 0, 0,       0, 0, 32'h530, 9, 4, 0, 1);
        vecs[23] = mk(0, 0, 0, 0,             1, 1, 32'h780, 0, 0, 32'h530, 10, 4, 0, 0);
        // wrong-path suppression
        vecs[24] = mk(1, 32'h900, 0, 0,       0, 0, 0,       0, 0, 32'h530, 10, 4, 0, 1);
        vecs[25] = mk(1, 32'h904, 0, 0,       0, 0, 0,       0, 0, 32'h530, 10, 4, 0, 2);
        vecs[26] = mk(1, 32'h908, 0, 0,       0, 0, 0,       0, 0, 32'h530, 10, 4, 0, 3);
        vecs[27] = mk(1, 32'h90C, 0, 0,       1, 1, 32'hA00, 0, 1, 32'hA00, 11, 5, 0, 3);
        vecs[28] = mk(1, 32'h910, 0, 0,       1, 0, 0,       0, 0, 32'hA00, 11, 5, 0, 0);
        vecs[29] = mk(0, 0, 0, 0,             0, 0, 0,       0, 0, 32'hA00, 11, 5, 0, 0);
        // resolve with nothing outstanding
        vecs[30] = mk(0, 0, 0, 0,             1, 1, 32'h123, 0, 0, 32'hA00, 11, 5, 1, 0);
        vecs[31] = mk(1, 32'hB00, 0, 0,       0, 0, 0,       0, 0, 32'hA00, 11, 5, 1, 1);
        vecs[32] = mk(0, 0, 0, 0,             1, 0, 0,       0, 0, 32'hA00, 12, 5, 1, 0);

        rst_n = 1'b0;
        idle_main();
        s_push = 0; s_pc = 0; s_pt = 0; s_ptgt = 0; s_res = 0; s_at = 0; s_atgt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'b0, stall_f}, 32'd0);
        chk("reset_flush_fd", {31'b0, flush_fd}, 32'd0);
        chk("reset_flush_de", {31'b0, flush_de}, 32'd0);
        chk("reset_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_branch_count", branch_count, 32'd0);
        chk("reset_mispredict_count", mispredict_count, 32'd0);
        chk("reset_underflow", {31'b0, underflow_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            f_push = vecs[i].push; f_pc = vecs[i].pc;
            f_predict_taken = vecs[i].pt; f_pred_target = vecs[i].ptgt;
            e_resolve = vecs[i].res; e_actual_taken = vecs[i].at;
            e_actual_target = vecs[i].atgt;
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, stall_f}, {31'b0, vecs[i].exp_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_flush_fd", i), {31'b0, flush_fd}, {31'b0, vecs[i].exp_flush});
            chk($sformatf("v%0d_flush_de", i), {31'b0, flush_de}, {31'b0, vecs[i].exp_flush});
            chk($sformatf("v%0d_redirect_valid", i), {31'b0, redirect_valid}, {31'b0, vecs[i].exp_flush});
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
            chk($sformatf("v%0d_branch_count", i), branch_count, 32'(vecs[i].exp_bc));
            chk($sformatf("v%0d_mispredict_count", i), mispredict_count, 32'(vecs[i].exp_mc));
            chk($sformatf("v%0d_underflow", i), {31'b0, underflow_err}, {31'b0, vecs[i].exp_uf});
            chk($sformatf("v%0d_qcount", i), 32'(dut.u_queue.count), 32'(vecs[i].exp_cnt));
            $display("vec %0d: push=%0b pc=0x%0h res=%0b taken=%0b -> flush=%0b rpc=0x%0h bc=%0d mc=%0d",
                     i, vecs[i].push, vecs[i].pc, vecs[i].res, vecs[i].at,
                     flush_fd, redirect_pc, branch_count, mispredict_count);
        end

        // asynchronous reset while in RECOVER
        @(negedge clk);
        idle_main();
        f_push = 1; f_pc = 32'hC00;
        @(negedge clk);
        idle_main();
        e_resolve = 1; e_actual_taken = 1; e_actual_target = 32'hC40;
        @(posedge clk);
        #1;
        chk("rcv_flush_before_reset", {31'b0, flush_fd}, 32'd1);
        chk("rcv_redirect_pc_before_reset", redirect_pc, 32'hC40);
        idle_main();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rcv_reset_flush_fd", {31'b0, flush_fd}, 32'd0);
        chk("rcv_reset_flush_de", {31'b0, flush_de}, 32'd0);
        chk("rcv_reset_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        chk("rcv_reset_redirect_pc", redirect_pc, 32'd0);
        chk("rcv_reset_branch_count", branch_count, 32'd0);
        chk("rcv_reset_underflow", {31'b0, underflow_err}, 32'd0);
        $display("reset during recover: flush=%0b rpc=0x%0h bc=%0d", flush_fd, redirect_pc, branch_count);
        @(negedge clk);
        rst_n = 1'b1;
        f_push = 1; f_pc = 32'hD00; f_predict_taken = 1; f_pred_target = 32'hD80;
        @(negedge clk);
        idle_main();
        e_resolve = 1; e_actual_taken = 1; e_actual_target = 32'hD80;
        @(posedge clk);
        #1;
        chk("post_reset_flush", {31'b0, flush_fd}, 32'd0);
        chk("post_reset_branch_count", branch_count, 32'd1);
        chk("post_reset_mispredict_count", mispredict_count, 32'd0);
        chk("post_reset_qcount", 32'(dut.u_queue.count), 32'd0);
        $display("after reset: correct pop bc=%0d mc=%0d", branch_count, mispredict_count);
        @(negedge clk);
        idle_main();

        // saturation on the 2-bit-counter instance
        for (int r = 0; r < 5; r++) begin
            int exp_sat;
            @(negedge clk);
            s_push = 1; s_pc = 32'h40 * r; s_pt = 0;
            @(negedge clk);
            s_push = 0; s_res = 1; s_at = 1; s_atgt = 32'h1000;
            @(negedge clk);
            s_res = 0;
            @(negedge clk);
            exp_sat = (r + 1 > 3) ? 3 : r + 1;
            chk($sformatf("sat%0d_branch_count", r), {30'b0, s_bc}, 32'(exp_sat));
            chk($sformatf("sat%0d_mispredict_count", r), {30'b0, s_mc}, 32'(exp_sat));
            $display("saturation round %0d: bc=%0d mc=%0d", r, s_bc, s_mc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
